id_hazard_ctrl: RTL and testbench
=================================

ID_HAZARD_CTRL -- requirements
Module: id_hazard_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset_n, input, 1; reset is asynchronous and active-low.
REQ-003 SHALL have port IF_ID_rs, IF_ID_rt, input, 5 each; source registers of the instruction in ID.
REQ-004 SHALL have port ID_uses_rs, ID_uses_rt, input, 1 each; the ID instruction reads that operand.
REQ-005 SHALL have port ID_Branch, input, 1; the ID instruction is a branch or jr resolved in ID.
REQ-006 SHALL have port Branch_taken, input, 1; ID comparator or jump result.
REQ-007 SHALL have port ID_EX_RegWrite, ID_EX_MemRead, input, 1 each; ID_EX_Write_register, input, 5.
REQ-008 SHALL have port EX_MEM_MemRead, input, 1; EX_MEM_Write_register, input, 5.
REQ-009 SHALL have port ext_stall, input, 1; memory-wait freeze request.
REQ-010 SHALL have port cnt_clr, input, 1; synchronous clear of both counters.
REQ-011 SHALL have port PC_Write, IF_ID_Write, output, 1 each; write enables for PC and IF/ID.
REQ-012 SHALL have port ID_EX_Flush, output, 1; inserts a bubble into ID/EX.
REQ-013 SHALL have port IF_ID_Flush, output, 1; squashes the fetched instruction.
REQ-014 SHALL have port stall_cycles, flush_count, output, 16 each; performance counters.

Function
REQ-015 Match terms SHALL be: mEX = (ID_EX_Write_register != 0) && ((ID_uses_rs && ID_EX_Write_register == IF_ID_rs) || (ID_uses_rt && ID_EX_Write_register == IF_ID_rt)); mMEM is the same test on EX_MEM_Write_register.
REQ-016 FSM states SHALL be RUN and LDW.
REQ-017 In RUN, hz2 = ID_Branch && ID_EX_MemRead && mEX SHALL stall and set next state LDW.
REQ-018 In RUN, hz1 = (ID_Branch && ID_EX_RegWrite && !ID_EX_MemRead && mEX) || (ID_Branch && EX_MEM_MemRead && mMEM) || (!ID_Branch && ID_EX_MemRead && mEX) SHALL stall one cycle and stay in RUN, so the hazard is re-evaluated on the next cycle.
REQ-019 In LDW, the block SHALL stall unconditionally and return to RUN, giving exactly 2 stall cycles for a load feeding a branch.
REQ-020 Stall SHALL drive PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1, IF_ID_Flush=0.
REQ-021 No stall SHALL drive PC_Write=1, IF_ID_Write=1, ID_EX_Flush=0, IF_ID_Flush=Branch_taken && ID_Branch.
REQ-022 ext_stall=1 SHALL override everything: PC_Write=0, IF_ID_Write=0, both flushes 0, state held, counters held.
REQ-023 Outputs SHALL be combinational from state and inputs, with zero-cycle latency.
REQ-024 stall_cycles SHALL increment in each cycle where ID_EX_Flush=1; flush_count SHALL increment in each cycle where IF_ID_Flush=1.
REQ-025 Both counters SHALL saturate at 16'hFFFF, with no wrap-around.
REQ-026 cnt_clr SHALL win over a simultaneous increment, giving 0 on the next edge.
REQ-027 Register 0 SHALL never create a hazard.

Reset
REQ-028 While reset_n=0, the state SHALL be RUN and both counters 0.
REQ-029 While reset_n=0, outputs SHALL be PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1, IF_ID_Flush=1.
REQ-030 Reset asserted in LDW SHALL abort the stall immediately, and after deassertion the FSM SHALL start in RUN.

Structure
REQ-031 The shared package SHALL hold the state enum (RUN, LDW), the constant REG_ZERO=5'd0 and CNT_W=16.
REQ-032 One sub-module, sat_counter (CNT_W-bit, enable, clear, saturate), SHALL be instantiated twice.

Verification
REQ-033 lw $5 in EX, beq $5,$6 in ID -> stall 2 cycles (ID_EX_Flush=1,1), then beq proceeds; stall_cycles=2.
REQ-034 add $5 in EX, beq $5,$0 in ID -> exactly 1 stall, then FA_ID forwarding path used; stall_cycles=1.
REQ-035 lw $7 in EX, add $8,$7,$7 in ID -> 1 stall; lw $0 in EX -> no stall.
REQ-036 beq taken with no hazard -> IF_ID_Flush=1 for one cycle, flush_count=1; with ext_stall=1 in that cycle -> no flush, counters unchanged.
REQ-037 Reset pulse while in LDW -> state RUN, counters 0, reset-time outputs per REQ-029.
REQ-038 Preload stall_cycles=16'hFFFF by forcing stalls -> value holds at FFFF; cnt_clr with stall active -> 0.

Source files
------------

// File: rtl/id_hazard_ctrl_pkg.sv
// Shared types and constants for the ID-stage hazard controller.
// Holds the FSM state enum, the zero-register constant and counter width.
package id_hazard_ctrl_pkg;

   typedef enum logic {
      RUN = 1'b0,
      LDW = 1'b1
   } state_e;

   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam int         CNT_W    = 16;

   // True when a producer writing 'wr' feeds an operand the ID instruction reads.
   function automatic logic reg_match(
      input logic [4:0] wr,
      input logic [4:0] rs,
      input logic [4:0] rt,
      input logic       use_rs,
      input logic       use_rt
   );
      return (wr != REG_ZERO) && ((use_rs && (wr == rs)) || (use_rt && (wr == rt)));
   endfunction

endpackage

// File: rtl/id_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
// Latency: one cycle from enable to count; no backpressure, holds at all-ones.
module sat_counter
   import id_hazard_ctrl_pkg::*;
#(
   parameter int W = CNT_W
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         en,
   input  logic         clr,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/id_hazard_ctrl.sv
// ID-stage load-use / branch hazard controller with stall and flush counters.
// Latency: outputs are combinational (0 cycles); ext_stall freezes state, outputs and counters.
module id_hazard_ctrl
   import id_hazard_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic [4:0]       IF_ID_rs,
   input  logic [4:0]       IF_ID_rt,
   input  logic             ID_uses_rs,
   input  logic             ID_uses_rt,
   input  logic             ID_Branch,
   input  logic             Branch_taken,
   input  logic             ID_EX_RegWrite,
   input  logic             ID_EX_MemRead,
   input  logic [4:0]       ID_EX_Write_register,
   input  logic             EX_MEM_MemRead,
   input  logic [4:0]       EX_MEM_Write_register,
   input  logic             ext_stall,
   input  logic             cnt_clr,
   output logic             PC_Write,
   output logic             IF_ID_Write,
   output logic             ID_EX_Flush,
   output logic             IF_ID_Flush,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   state_e state_q;
   state_e state_d;
   logic   m_ex;
   logic   m_mem;
   logic   hz1;
   logic   hz2;
   logic   stall;

   assign m_ex  = reg_match(ID_EX_Write_register, IF_ID_rs, IF_ID_rt, ID_uses_rs, ID_uses_rt);
   assign m_mem = reg_match(EX_MEM_Write_register, IF_ID_rs, IF_ID_rt, ID_uses_rs, ID_uses_rt);

   // A load feeding a branch needs two bubbles; every other hazard needs one.
   assign hz2 = ID_Branch && ID_EX_MemRead && m_ex;
   assign hz1 = (ID_Branch && ID_EX_RegWrite && !ID_EX_MemRead && m_ex)
             || (ID_Branch && EX_MEM_MemRead && m_mem)
             || (!ID_Branch && ID_EX_MemRead && m_ex);

   always_comb begin
      state_d     = state_q;
      stall       = 1'b0;
      PC_Write    = 1'b1;
      IF_ID_Write = 1'b1;
      ID_EX_Flush = 1'b0;
      IF_ID_Flush = 1'b0;

      case (state_q)
         RUN: begin
            if (hz2) begin
               stall   = 1'b1;
               state_d = LDW;
            end else if (hz1) begin
               stall   = 1'b1;
            end
         end
         LDW: begin
            stall   = 1'b1;
            state_d = RUN;
         end
         default: begin
            state_d = RUN;
         end
      endcase

      if (ext_stall) begin
         state_d = state_q;
      end

      if (!reset_n) begin
         PC_Write    = 1'b0;
         IF_ID_Write = 1'b0;
         ID_EX_Flush = 1'b1;
         IF_ID_Flush = 1'b1;
      end else if (ext_stall) begin
         PC_Write    = 1'b0;
         IF_ID_Write = 1'b0;
      end else if (stall) begin
         PC_Write    = 1'b0;
         IF_ID_Write = 1'b0;
         ID_EX_Flush = 1'b1;
      end else begin
         IF_ID_Flush = Branch_taken && ID_Branch;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (ID_EX_Flush),
      .clr     (cnt_clr && !ext_stall),
      .cnt     (stall_cycles)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (IF_ID_Flush),
      .clr     (cnt_clr && !ext_stall),
      .cnt     (flush_count)
   );

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed bench for id_hazard_ctrl: hand-computed control vectors and counter values.
module tb_id_hazard_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [4:0]  IF_ID_rs, IF_ID_rt;
   logic        ID_uses_rs, ID_uses_rt;
   logic        ID_Branch, Branch_taken;
   logic        ID_EX_RegWrite, ID_EX_MemRead;
   logic [4:0]  ID_EX_Write_register;
   logic        EX_MEM_MemRead;
   logic [4:0]  EX_MEM_Write_register;
   logic        ext_stall, cnt_clr;
   logic        PC_Write, IF_ID_Write, ID_EX_Flush, IF_ID_Flush;
   logic [15:0] stall_cycles, flush_count;
   logic [3:0]  outs;

   int vecs = 0;
   int errs = 0;

   // outs = {PC_Write, IF_ID_Write, ID_EX_Flush, IF_ID_Flush}
   assign outs = {PC_Write, IF_ID_Write, ID_EX_Flush, IF_ID_Flush};

   always #5 clk = ~clk;

   id_hazard_ctrl dut (
      .clk                   (clk),
      .reset_n               (reset_n),
      .IF_ID_rs              (IF_ID_rs),
      .IF_ID_rt              (IF_ID_rt),
      .ID_uses_rs            (ID_uses_rs),
      .ID_uses_rt            (ID_uses_rt),
      .ID_Branch             (ID_Branch),
      .Branch_taken          (Branch_taken),
      .ID_EX_RegWrite        (ID_EX_RegWrite),
      .ID_EX_MemRead         (ID_EX_MemRead),
      .ID_EX_Write_register  (ID_EX_Write_register),
      .EX_MEM_MemRead        (EX_MEM_MemRead),
      .EX_MEM_Write_register (EX_MEM_Write_register),
      .ext_stall             (ext_stall),
      .cnt_clr               (cnt_clr),
      .PC_Write              (PC_Write),
      .IF_ID_Write           (IF_ID_Write),
      .ID_EX_Flush           (ID_EX_Flush),
      .IF_ID_Flush           (IF_ID_Flush),
      .stall_cycles          (stall_cycles),
      .flush_count           (flush_count)
   );

   task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                         input logic urt, input logic br, input logic tk);
      IF_ID_rs = rs; IF_ID_rt = rt; ID_uses_rs = urs; ID_uses_rt = urt;
      ID_Branch = br; Branch_taken = tk;
   endtask

   task automatic set_ex(input logic rw, input logic mr, input logic [4:0] wr);
      ID_EX_RegWrite = rw; ID_EX_MemRead = mr; ID_EX_Write_register = wr;
   endtask

   task automatic set_mem(input logic mr, input logic [4:0] wr);
      EX_MEM_MemRead = mr; EX_MEM_Write_register = wr;
   endtask

   task automatic idle();
      set_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      set_ex(1'b0, 1'b0, 5'd0);
      set_mem(1'b0, 5'd0);
      ext_stall = 1'b0;
      cnt_clr   = 1'b0;
   endtask

   task automatic clear_counters();
      @(negedge clk); idle(); cnt_clr = 1'b1;
      @(negedge clk); cnt_clr = 1'b0; #1;
      vecs++;
      if (stall_cycles !== 16'd0 || flush_count !== 16'd0) begin
         errs++;
         $display("FAIL clr stall=%h flush=%h exp 0/0", stall_cycles, flush_count);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; idle();
      #12;
      vecs++;
      if (outs !== 4'b0011) begin errs++; $display("FAIL reset_outs got=%b exp=0011", outs); end
      vecs++;
      if (stall_cycles !== 16'd0 || flush_count !== 16'd0) begin
         errs++; $display("FAIL reset_cnt stall=%h flush=%h exp 0/0", stall_cycles, flush_count);
      end
      @(negedge clk); reset_n = 1'b1; #1;
      vecs++;
      if (outs !== 4'b1100) begin errs++; $display("FAIL reset_run got=%b exp=1100", outs); end
   endtask

   // lw $5 in EX, beq $5,$6 in ID
   task automatic test_load_branch();
      clear_counters();
      @(negedge clk); set_id(5'd5, 5'd6, 1, 1, 1, 0); set_ex(1, 1, 5'd5); set_mem(0, 5'd0); #1;
      vecs++;
      if (outs !== 4'b0010) begin errs++; $display("FAIL ldbr_c1 got=%b exp=0010", outs); end
      @(negedge clk); set_ex(0, 0, 5'd0); set_mem(1, 5'd5); #1;
      vecs++;
      if (outs !== 4'b0010) begin errs++; $display("FAIL ldbr_c2 got=%b exp=0010", outs); end
      @(negedge clk); set_mem(0, 5'd0); #1;
      vecs++;
      if (outs !== 4'b1100) begin errs++; $display("FAIL ldbr_go got=%b exp=1100", outs); end
      vecs++;
      if (stall_cycles !== 16'd2) begin errs++; $display("FAIL ldbr_cnt got=%0d exp=2", stall_cycles); end
   endtask

   // add $5 in EX, beq $5,$0 in ID
   task automatic test_alu_branch();
      clear_counters();
      @(negedge clk); set_id(5'd5, 5'd0, 1, 1, 1, 0); set_ex(1, 0, 5'd5); set_mem(0, 5'd0); #1;
      vecs++;
      if (outs !== 4'b0010) begin errs++; $display("FAIL alubr_c1 got=%b exp=0010", outs); end
      @(negedge clk); set_ex(0, 0, 5'd0); set_mem(0, 5'd5); #1;
      vecs++;
      if (outs !== 4'b1100) begin errs++; $display("FAIL alubr_go got=%b exp=1100", outs); end
      vecs++;
      if (stall_cycles !== 16'd1) begin errs++; $display("FAIL alubr_cnt got=%0d exp=1", stall_cycles); end
   endtask

   // lw $7 in EX, add $8,$7,$7 in ID; then register-0 and unused-operand cases
   task automatic test_load_use();
      clear_counters();
      @(negedge clk); set_id(5'd7, 5'd7, 1, 1, 0, 0); set_ex(1, 1, 5'd7); set_mem(0, 5'd0); #1;
      vecs++;
      if (outs !== 4'b0010) begin errs++; $display("FAIL ldu_c1 got=%b exp=0010", outs); end
      @(negedge clk); set_ex(0, 0, 5'd0); set_mem(1, 5'd7); #1;
      vecs++;
      if (outs !== 4'b1100) begin errs++; $display("FAIL ldu_go got=%b exp=1100", outs); end
      @(negedge clk); set_id(5'd0, 5'd0, 1, 1, 0, 0); set_ex(1, 1, 5'd0); set_mem(0, 5'd0); #1;
      vecs++;
      if (outs !== 4'b1100) begin errs++; $display("FAIL ld_r0 got=%b exp=1100", outs); end
      @(negedge clk); set_id(5'd7, 5'd3, 0, 1, 0, 0); set_ex(1, 1, 5'd7); #1;
      vecs++;
      if (outs !== 4'b1100) begin errs++; $display("FAIL ld_unused got=%b exp=1100", outs); end
      vecs++;
      if (stall_cycles !== 16'd1) begin errs++; $display("FAIL ldu_cnt got=%0d exp=1", stall_cycles); end
   endtask

   task automatic test_branch_flush();
      clear_counters();
      @(negedge clk); set_id(5'd1, 5'd2, 1, 1, 1, 1); #1;
      vecs++;
      if (outs !== 4'b1101) begin errs++; $display("FAIL brf_outs got=%b exp=1101", outs); end
      @(negedge clk); ext_stall = 1'b1; #1;
      vecs++;
      if (flush_count !== 16'd1) begin errs++; $display("FAIL brf_cnt got=%0d exp=1", flush_count); end
      vecs++;
      if (outs !== 4'b0000) begin errs++; $display("FAIL brf_ext got=%b exp=0000", outs); end
      @(negedge clk); ext_stall = 1'b0; set_id(5'd1, 5'd2, 1, 1, 1, 0); #1;
      vecs++;
      if (flush_count !== 16'd1 || stall_cycles !== 16'd0) begin
         errs++; $display("FAIL brf_hold flush=%0d stall=%0d exp 1/0", flush_count, stall_cycles);
      end
   endtask

   // ext_stall while in LDW must hold the state
   task automatic test_ext_stall_hold();
      clear_counters();
      @(negedge clk); set_id(5'd4, 5'd0, 1, 0, 1, 0); set_ex(1, 1, 5'd4); #1;
      vecs++;
      if (outs !== 4'b0010) begin errs++; $display("FAIL exh_c1 got=%b exp=0010", outs); end
      @(negedge clk); set_ex(0, 0, 5'd0); ext_stall = 1'b1; #1;
      vecs++;
      if (outs !== 4'b0000) begin errs++; $display("FAIL exh_frz got=%b exp=0000", outs); end
      @(negedge clk); ext_stall = 1'b0; #1;
      vecs++;
      if (outs !== 4'b0010) begin errs++; $display("FAIL exh_ldw got=%b exp=0010", outs); end
      @(negedge clk); #1;
      vecs++;
      if (outs !== 4'b1100) begin errs++; $display("FAIL exh_go got=%b exp=1100", outs); end
      vecs++;
      if (stall_cycles !== 16'd2) begin errs++; $display("FAIL exh_cnt got=%0d exp=2", stall_cycles); end
   endtask

   task automatic test_reset_in_ldw();
      @(negedge clk); idle(); set_id(5'd9, 5'd0, 1, 0, 1, 0); set_ex(1, 1, 5'd9);
      @(negedge clk); set_ex(0, 0, 5'd0); set_id(5'd9, 5'd0, 1, 0, 1, 1); reset_n = 1'b0; #1;
      vecs++;
      if (outs !== 4'b0011) begin errs++; $display("FAIL rldw_outs got=%b exp=0011", outs); end
      vecs++;
      if (stall_cycles !== 16'd0 || flush_count !== 16'd0) begin
         errs++; $display("FAIL rldw_cnt stall=%h flush=%h exp 0/0", stall_cycles, flush_count);
      end
      @(negedge clk); reset_n = 1'b1; #1;
      vecs++;
      if (outs !== 4'b1101) begin errs++; $display("FAIL rldw_run got=%b exp=1101", outs); end
   endtask

   task automatic test_saturation();
      clear_counters();
      @(negedge clk); set_id(5'd7, 5'd0, 1, 0, 0, 0); set_ex(1, 1, 5'd7);
      repeat (65534) @(posedge clk);
      @(negedge clk); #1;
      vecs++;
      if (stall_cycles !== 16'hFFFE) begin errs++; $display("FAIL sat_fffe got=%h exp=fffe", stall_cycles); end
      @(negedge clk); #1;
      vecs++;
      if (stall_cycles !== 16'hFFFF) begin errs++; $display("FAIL sat_ffff got=%h exp=ffff", stall_cycles); end
      repeat (3) @(negedge clk);
      #1;
      vecs++;
      if (stall_cycles !== 16'hFFFF) begin errs++; $display("FAIL sat_hold got=%h exp=ffff", stall_cycles); end
      cnt_clr = 1'b1; #1;
      vecs++;
      if (outs !== 4'b0010) begin errs++; $display("FAIL sat_stall got=%b exp=0010", outs); end
      @(negedge clk); cnt_clr = 1'b0; #1;
      vecs++;
      if (stall_cycles !== 16'd0) begin errs++; $display("FAIL sat_clr got=%h exp=0", stall_cycles); end
      @(negedge clk); #1;
      vecs++;
      if (stall_cycles !== 16'd1) begin errs++; $display("FAIL sat_restart got=%h exp=1", stall_cycles); end
   endtask

   initial begin
      test_reset();
      test_load_branch();
      test_alu_branch();
      test_load_use();
      test_branch_flush();
      test_ext_stall_hold();
      test_reset_in_ldw();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
